// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, round constants, S-box tables and GF(2^8) helpers.
// Everything here is purely combinational; the polynomial is x^8+x^4+x^3+x+1 (0x11B).
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_EXP,
    ST_ADD_INIT,
    ST_ROUND,
    ST_DONE
  } state_e;

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Key-schedule constant for step k (1..10); other values never reach the datapath.
  function automatic logic [7:0] rcon(input logic [3:0] k);
    logic [7:0] r;
    r = 8'h00;
    if (k >= 4'd1 && k <= 4'd10) r = RCON[k - 4'd1];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_128_inv_cipher_if.sv
// Request/result bundle of the AES-128 decryption core; master drives start and operands.
// No backpressure: start is only honoured while the core is idle.
interface aes_128_inv_cipher_if;
  logic         start;
  logic [127:0] ciphertext;
  logic [127:0] master_key;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;

  modport master (output start, ciphertext, master_key, input plaintext, busy, done);
  modport slave  (input start, ciphertext, master_key, output plaintext, busy, done);
endinterface

// File: rtl/aes_inv_round.sv
// One inverse AES round, combinational: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless last_round_i is set. Byte 0 sits in bits 127:120, column-major.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_round_i,
  output logic [127:0] state_o
);

  logic [0:15][7:0] s_in;
  logic [0:15][7:0] rk_b;
  logic [0:15][7:0] ak;
  logic [0:15][7:0] mc;

  assign s_in = state_i;
  assign rk_b = rk_i;

  always_comb begin
    ak = '0;
    mc = '0;
    // Row r is rotated right by r columns, so output column c reads input column c-r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ak[4*c+r] = INV_SBOX[s_in[4*((c-r+4)%4)+r]] ^ rk_b[4*c+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = mule(ak[4*c]) ^ mulb(ak[4*c+1]) ^ muld(ak[4*c+2]) ^ mul9(ak[4*c+3]);
      mc[4*c+1] = mul9(ak[4*c]) ^ mule(ak[4*c+1]) ^ mulb(ak[4*c+2]) ^ muld(ak[4*c+3]);
      mc[4*c+2] = muld(ak[4*c]) ^ mul9(ak[4*c+1]) ^ mule(ak[4*c+2]) ^ mulb(ak[4*c+3]);
      mc[4*c+3] = mulb(ak[4*c]) ^ muld(ak[4*c+1]) ^ mul9(ak[4*c+2]) ^ mule(ak[4*c+3]);
    end
  end

  assign state_o = last_round_i ? ak : mc;

endmodule

// File: rtl/aes_128_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock; done 21 edges after accept (11 on a key-cache hit).
// start is ignored unless idle; AES_KEY_CACHE_EN enables reuse of the expanded key for a repeated master_key.
module aes_128_inv_cipher
  import aes_pkg::*;
#(
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  aes_128_inv_cipher_if.slave        bus
);

  state_e                 fsm_q, fsm_d;
  logic [127:0]           blk_q, blk_d;
  logic [127:0]           pt_q, pt_d;
  logic [0:NR][127:0]     rk_q, rk_d;
  logic [3:0]             round_q, round_d;
  logic                   done_q, done_d;

  logic [127:0]           round_out;
  logic [127:0]           rk_prev;
  logic [127:0]           rk_next;
  logic [31:0]            ks_tmp;
  logic                   hit;

`ifdef AES_KEY_CACHE_EN
  logic [127:0]           tag_q, tag_d;
  logic                   vld_q, vld_d;

  assign hit = vld_q && (bus.master_key == tag_q);
`else
  assign hit = 1'b0;
`endif

  aes_inv_round u_round (
    .state_i      (blk_q),
    .rk_i         (rk_q[round_q]),
    .last_round_i (round_q == 4'd0),
    .state_o      (round_out)
  );

  // Forward key step: round_q doubles as the expansion index k while in KEY_EXP.
  always_comb begin
    rk_prev = rk_q[round_q - 4'd1];
    ks_tmp  = {SBOX[rk_prev[23:16]], SBOX[rk_prev[15:8]], SBOX[rk_prev[7:0]], SBOX[rk_prev[31:24]]}
              ^ {rcon(round_q), 24'h000000};
    rk_next[127:96] = rk_prev[127:96] ^ ks_tmp;
    rk_next[95:64]  = rk_prev[95:64]  ^ rk_next[127:96];
    rk_next[63:32]  = rk_prev[63:32]  ^ rk_next[95:64];
    rk_next[31:0]   = rk_prev[31:0]   ^ rk_next[63:32];
  end

  always_comb begin
    fsm_d   = fsm_q;
    blk_d   = blk_q;
    pt_d    = pt_q;
    rk_d    = rk_q;
    round_d = round_q;
    done_d  = done_q;
`ifdef AES_KEY_CACHE_EN
    tag_d   = tag_q;
    vld_d   = vld_q;
`endif
    unique case (fsm_q)
      ST_IDLE: begin
        if (bus.start) begin
          blk_d     = bus.ciphertext;
          rk_d[0]   = bus.master_key;
          done_d    = 1'b0;
          if (hit) begin
            fsm_d = ST_ADD_INIT;
          end else begin
            fsm_d   = ST_KEY_EXP;
            round_d = 4'd1;
`ifdef AES_KEY_CACHE_EN
            vld_d   = 1'b0;
`endif
          end
        end
      end
      ST_KEY_EXP: begin
        rk_d[round_q] = rk_next;
        if (round_q == 4'(NR)) begin
          fsm_d = ST_ADD_INIT;
`ifdef AES_KEY_CACHE_EN
          tag_d = rk_q[0];
          vld_d = 1'b1;
`endif
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      ST_ADD_INIT: begin
        blk_d   = blk_q ^ rk_q[NR];
        round_d = 4'(NR - 1);
        fsm_d   = ST_ROUND;
      end
      ST_ROUND: begin
        blk_d = round_out;
        if (round_q == 4'd0) begin
          pt_d   = round_out;
          done_d = 1'b1;
          fsm_d  = ST_DONE;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
      ST_DONE: begin
        fsm_d  = ST_IDLE;
        done_d = DONE_HOLD;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      blk_q   <= '0;
      pt_q    <= '0;
      rk_q    <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
`ifdef AES_KEY_CACHE_EN
      tag_q   <= '0;
      vld_q   <= 1'b0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      blk_q   <= blk_d;
      pt_q    <= pt_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      done_q  <= done_d;
`ifdef AES_KEY_CACHE_EN
      tag_q   <= tag_d;
      vld_q   <= vld_d;
`endif
    end
  end

  assign bus.plaintext = pt_q;
  assign bus.done      = done_q;
  assign bus.busy      = (fsm_q == ST_KEY_EXP) || (fsm_q == ST_ADD_INIT) || (fsm_q == ST_ROUND);

endmodule
